// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-ported mem block between the instruction-fetch port
// (read-only) and the data port (read/write). Sequences the mem strobe
// protocol (en/rw/addr/in) and waits on the asynchronous MFC completion flag.
// Each transaction ends with a one-cycle acknowledge to the granted port,
// carrying read data and a timeout error flag.
//
// Transaction flow: IDLE -> SETUP -> ISSUE -> RELEASE -> DONE.
//   SETUP   : bus driven with mem_en low, so the mem posedge-en latch sees
//             stable address/data.
//   ISSUE   : mem_en high until the synchronized MFC rises or TIMEOUT expires.
//   RELEASE : mem_en low until the synchronized MFC falls or TIMEOUT expires.
//   DONE    : ack pulse to the grantee.
//
// Parameters
//   DATA_W   data bus width (16 for mem)
//   ADDR_W   address bus width (16 for mem)
//   TIMEOUT  cycles allowed in ISSUE or RELEASE before aborting; must be
//            in the range 4..255 (8-bit counter)
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   f_req/f_addr        fetch request (held until f_ack) and address
//   f_ack/f_rdata/f_err fetch completion pulse, read data, timeout flag
//   d_req/d_rw          data request (held until d_ack), 1 = read, 0 = write
//   d_addr/d_wdata      data address and write data
//   d_ack/d_rdata/d_err data completion pulse, read data (0 on writes), flag
//   mem_en/mem_rw       mem strobe and direction
//   mem_addr/mem_in     mem address and write data
//   mem_mfc/mem_out     mem completion flag (asynchronous) and read data
//   busy                high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  // data port
  input  logic              d_req,
  input  logic              d_rw,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  // mem side
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic              mem_mfc,
  input  logic [DATA_W-1:0] mem_out,
  // status
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ISSUE   = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // Grantee encoding, also used for the round-robin "last" bit.
  localparam logic GNT_F = 1'b0;
  localparam logic GNT_D = 1'b1;

  localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

  state_t              r_state;
  state_t              w_next;

  logic                r_mfc_p0;
  logic                r_mfc_p1;
  logic                w_mfc_s;

  logic [7:0]          r_cnt;
  logic [7:0]          w_cnt_inc;
  logic                w_cnt_hit;

  logic                r_last;
  logic                r_gnt;
  logic                r_err_pend;
  logic [DATA_W-1:0]   r_rd;

  logic                r_en;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_in;

  logic                r_f_ack;
  logic [DATA_W-1:0]   r_f_rdata;
  logic                r_f_err;
  logic                r_d_ack;
  logic [DATA_W-1:0]   r_d_rdata;
  logic                r_d_err;

  logic                w_rf;
  logic                w_rd;
  logic                w_any;
  logic                w_sel;
  logic                w_take;
  logic                w_issue_ok;
  logic                w_to;
  logic                w_done_in;
  logic                w_err_final;
  logic [DATA_W-1:0]   w_rdata_final;

  // ---------------------------------------------------------------------------
  // MFC synchronizer: two flops, w_mfc_s is the only MFC the FSM looks at.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mfc_p0 <= 1'b0;
      r_mfc_p1 <= 1'b0;
    end else begin
      r_mfc_p0 <= mem_mfc;
      r_mfc_p1 <= r_mfc_p0;
    end
  end

  assign w_mfc_s = r_mfc_p1;

  // ---------------------------------------------------------------------------
  // Arbitration. In DONE the acknowledged port is masked: its requester only
  // drops req on the edge that leaves DONE, so its still-high req must not be
  // taken as a new request. This lets DONE hand the bus straight to a waiting
  // other port, giving alternating conflicts an 8-cycle ack spacing.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rf = f_req;
    w_rd = d_req;
    if (r_state == S_DONE) begin
      w_rf = f_req & (r_gnt != GNT_F);
      w_rd = d_req & (r_gnt != GNT_D);
    end
  end

  assign w_any = w_rf | w_rd;
  // On conflict the port not served last wins; otherwise the sole requester.
  assign w_sel = (w_rf & w_rd) ? ~r_last : w_rd;

  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_cnt_hit = (w_cnt_inc == TO_VAL);

  // ---------------------------------------------------------------------------
  // Next-state logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next     = r_state;
    w_take     = 1'b0;
    w_issue_ok = 1'b0;
    w_to       = 1'b0;
    w_done_in  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_take = 1'b1;
          w_next = S_SETUP;
        end
      end
      S_SETUP: begin
        w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_mfc_s) begin
          w_issue_ok = 1'b1;
          w_next     = S_RELEASE;
        end else if (w_cnt_hit) begin
          w_to   = 1'b1;
          w_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // MFC falling takes priority over a simultaneous timeout.
        if (!w_mfc_s) begin
          w_done_in = 1'b1;
          w_next    = S_DONE;
        end else if (w_cnt_hit) begin
          w_to      = 1'b1;
          w_done_in = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        if (w_any) begin
          w_take = 1'b1;
          w_next = S_SETUP;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // A RELEASE timeout is flagged on the same edge that enters DONE, so fold
  // it in here rather than waiting for r_err_pend.
  assign w_err_final   = r_err_pend | w_to;
  assign w_rdata_final = w_err_final ? '0 : r_rd;

  // ---------------------------------------------------------------------------
  // FSM state, counter and transaction bookkeeping.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 8'd0;
      r_last     <= GNT_D;
      r_gnt      <= GNT_F;
      r_err_pend <= 1'b0;
      r_rd       <= '0;
    end else begin
      r_state <= w_next;

      // Cleared on entry to any state, counts while waiting on MFC.
      if (w_next != r_state) begin
        r_cnt <= 8'd0;
      end else if (r_state == S_ISSUE || r_state == S_RELEASE) begin
        r_cnt <= w_cnt_inc;
      end

      if (r_state == S_DONE) begin
        r_last <= r_gnt;
      end

      if (w_take) begin
        r_gnt      <= w_sel;
        r_err_pend <= 1'b0;
        r_rd       <= '0;
      end else begin
        if (w_to) begin
          r_err_pend <= 1'b1;
        end
        if (w_issue_ok) begin
          r_rd <= r_rw ? mem_out : '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // mem bus. Address/direction/data are latched at grant and otherwise hold;
  // mem_en is registered from the next state so it is high exactly in ISSUE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_rw   <= 1'b1;
      r_addr <= '0;
      r_in   <= '0;
    end else begin
      r_en <= (w_next == S_ISSUE);
      if (w_take) begin
        if (w_sel == GNT_D) begin
          r_addr <= d_addr;
          r_rw   <= d_rw;
          r_in   <= d_wdata;
        end else begin
          r_addr <= f_addr;
          r_rw   <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Completion outputs, loaded on entry to DONE. rdata/err hold until the
  // next completion for the same port; ack is a single-cycle pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_f_ack   <= 1'b0;
      r_f_rdata <= '0;
      r_f_err   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_d_rdata <= '0;
      r_d_err   <= 1'b0;
    end else begin
      r_f_ack <= w_done_in & (r_gnt == GNT_F);
      r_d_ack <= w_done_in & (r_gnt == GNT_D);
      if (w_done_in) begin
        if (r_gnt == GNT_F) begin
          r_f_rdata <= w_rdata_final;
          r_f_err   <= w_err_final;
        end else begin
          r_d_rdata <= w_rdata_final;
          r_d_err   <= w_err_final;
        end
      end
    end
  end

  assign f_ack    = r_f_ack;
  assign f_rdata  = r_f_rdata;
  assign f_err    = r_f_err;
  assign d_ack    = r_d_ack;
  assign d_rdata  = r_d_rdata;
  assign d_err    = r_d_err;
  assign mem_en   = r_en;
  assign mem_rw   = r_rw;
  assign mem_addr = r_addr;
  assign mem_in   = r_in;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with a behavioural mem model: mem latches on
// the rising edge of en and raises MFC 2 time units later, dropping it 2 time
// units after en falls. The model can be told to never raise MFC.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        f_req = 1'b0;
  logic [15:0] f_addr = 16'h0000;
  logic        f_ack;
  logic [15:0] f_rdata;
  logic        f_err;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b1;
  logic [15:0] d_addr = 16'h0000;
  logic [15:0] d_wdata = 16'h0000;
  logic        d_ack;
  logic [15:0] d_rdata;
  logic        d_err;
  logic        mem_en;
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [15:0] mem_in;
  logic        mem_mfc = 1'b0;
  logic [15:0] mem_out = 16'h0000;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  logic        stuck = 1'b0;
  time         t_bus = 0;
  logic [15:0] mem_arr [0:65535];

  mem_arbiter #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_in(mem_in),
    .mem_mfc(mem_mfc), .mem_out(mem_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mem model
  always @(posedge mem_en) begin
    if (mem_rw) mem_out = mem_arr[mem_addr];
    else        mem_arr[mem_addr] = mem_in;
    #2;
    if (!stuck && mem_en) mem_mfc = 1'b1;
  end

  always @(negedge mem_en) begin
    #2;
    mem_mfc = 1'b0;
  end

  // Bus must not move while mem_en is high, and must have been stable for a
  // full clock period when mem_en rises.
  always @(mem_addr or mem_rw or mem_in) begin
    t_bus = $time;
    if (rst === 1'b0) chk("bus_hold", 16'(mem_en), 16'd0);
  end

  always @(posedge mem_en) begin
    if (rst === 1'b0) chk("addr_setup", 16'(($time - t_bus) >= 10), 16'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input string tag, input logic is_d, input logic rw,
                         input logic [15:0] addr, input logic [15:0] wd,
                         output int lat, output int en_cyc,
                         output logic [15:0] rdata, output logic err,
                         output logic rw_seen);
    logic got;
    int   other;
    got = 1'b0; other = 0; lat = 0; en_cyc = 0;
    rdata = 16'h0000; err = 1'b0; rw_seen = 1'b1;
    if (is_d) begin
      d_req = 1'b1; d_rw = rw; d_addr = addr; d_wdata = wd;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    while (!got && lat < 60) begin
      tick();
      lat++;
      if (mem_en) begin
        en_cyc++;
        rw_seen = mem_rw;
      end
      if (is_d ? f_ack : d_ack) other++;
      if (is_d ? d_ack : f_ack) begin
        got   = 1'b1;
        rdata = is_d ? d_rdata : f_rdata;
        err   = is_d ? d_err : f_err;
      end
    end
    f_req = 1'b0;
    d_req = 1'b0;
    chk({tag, "_ack_seen"}, 16'(got), 16'd1);
    chk({tag, "_other_ack"}, 16'(other), 16'd0);
    tick();
    chk({tag, "_ack_pulse"}, 16'(is_d ? d_ack : f_ack), 16'd0);
    chk({tag, "_rdata_hold"}, is_d ? d_rdata : f_rdata, rdata);
  endtask

  initial begin
    int          lat;
    int          en_cyc;
    logic [15:0] rdata;
    logic        err;
    logic        rw_seen;
    int          na;
    int          dbl;
    int          acks;
    int          ack_t [4];
    logic        ack_p [4];
    logic [15:0] ack_d [4];

    for (int i = 0; i < 65536; i++) mem_arr[i] = 16'h0000;
    mem_arr[16'h0000] = 16'h50A3;
    mem_arr[16'h0001] = 16'h0081;
    mem_arr[16'h0007] = 16'h2083;

    // reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_mem_en", 16'(mem_en), 16'd0);
    chk("rst_mem_rw", 16'(mem_rw), 16'd1);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_in", mem_in, 16'h0000);
    chk("rst_f_ack", 16'(f_ack), 16'd0);
    chk("rst_d_ack", 16'(d_ack), 16'd0);
    chk("rst_f_err", 16'(f_err), 16'd0);
    chk("rst_d_err", 16'(d_err), 16'd0);
    chk("rst_f_rdata", f_rdata, 16'h0000);
    chk("rst_d_rdata", d_rdata, 16'h0000);
    chk("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    tick();
    tick();

    // fetch reads: ack lands on the 8th sample (edges 0..7)
    run_txn("f0", 1'b0, 1'b1, 16'h0000, 16'h0000, lat, en_cyc, rdata, err, rw_seen);
    chk("f0_lat", 16'(lat), 16'd8);
    chk("f0_data", rdata, 16'h50A3);
    chk("f0_err", 16'(err), 16'd0);
    chk("f0_en_cycles", 16'(en_cyc), 16'd3);
    run_txn("f7", 1'b0, 1'b1, 16'h0007, 16'h0000, lat, en_cyc, rdata, err, rw_seen);
    chk("f7_data", rdata, 16'h2083);
    chk("f7_err", 16'(err), 16'd0);

    // data write then read back
    run_txn("dw", 1'b1, 1'b0, 16'h0100, 16'h0001, lat, en_cyc, rdata, err, rw_seen);
    chk("dw_lat", 16'(lat), 16'd8);
    chk("dw_rdata", rdata, 16'h0000);
    chk("dw_err", 16'(err), 16'd0);
    chk("dw_rw_issue", 16'(rw_seen), 16'd0);
    chk("dw_bus_addr", mem_addr, 16'h0100);
    chk("dw_bus_in", mem_in, 16'h0001);
    run_txn("dr", 1'b1, 1'b1, 16'h0100, 16'h0000, lat, en_cyc, rdata, err, rw_seen);
    chk("dr_data", rdata, 16'h0001);
    chk("dr_rw_issue", 16'(rw_seen), 16'd1);
    chk("f_rdata_hold_across_d", f_rdata, 16'h2083);

    // timeout: MFC never rises
    stuck = 1'b1;
    run_txn("to", 1'b0, 1'b1, 16'h0007, 16'h0000, lat, en_cyc, rdata, err, rw_seen);
    chk("to_lat", 16'(lat), 16'd19);
    chk("to_en_cycles", 16'(en_cyc), 16'd16);
    chk("to_err", 16'(err), 16'd1);
    chk("to_rdata", rdata, 16'h0000);
    chk("to_busy_after", 16'(busy), 16'd0);
    stuck = 1'b0;
    run_txn("after_to", 1'b0, 1'b1, 16'h0000, 16'h0000, lat, en_cyc, rdata, err, rw_seen);
    chk("after_to_lat", 16'(lat), 16'd8);
    chk("after_to_data", rdata, 16'h50A3);
    chk("after_to_err", 16'(err), 16'd0);

    // round-robin with both requests held from reset
    rst = 1'b1;
    tick();
    f_req = 1'b1; f_addr = 16'h0007;
    d_req = 1'b1; d_rw = 1'b1; d_addr = 16'h0001;
    tick();
    rst = 1'b0;
    acks = 0; dbl = 0; na = 0;
    while (acks < 4 && na < 60) begin
      tick();
      na++;
      if (f_ack && d_ack) dbl++;
      if (f_ack && acks < 4) begin
        ack_t[acks] = na; ack_p[acks] = 1'b0; ack_d[acks] = f_rdata; acks++;
      end
      if (d_ack && acks < 4) begin
        ack_t[acks] = na; ack_p[acks] = 1'b1; ack_d[acks] = d_rdata; acks++;
      end
      if (acks == 4) begin
        f_req = 1'b0;
        d_req = 1'b0;
      end
    end
    f_req = 1'b0;
    d_req = 1'b0;
    chk("rr_ack_count", 16'(acks), 16'd4);
    chk("rr_double_ack", 16'(dbl), 16'd0);
    for (int i = 0; i < acks; i++) begin
      chk($sformatf("rr%0d_port", i), 16'(ack_p[i]), 16'(i % 2));
      chk($sformatf("rr%0d_time", i), 16'(ack_t[i]), 16'(8 * (i + 1)));
      chk($sformatf("rr%0d_data", i), ack_d[i], (i % 2 == 0) ? 16'h2083 : 16'h0081);
    end
    tick();
    tick();
    chk("rr_idle_after", 16'(busy), 16'd0);

    // reset during ISSUE
    f_req = 1'b1; f_addr = 16'h0000;
    tick();
    tick();
    chk("ri_en_in_issue", 16'(mem_en), 16'd1);
    chk("ri_busy_in_issue", 16'(busy), 16'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    f_req = 1'b0;
    #1;
    chk("ri_en_dropped", 16'(mem_en), 16'd0);
    chk("ri_busy", 16'(busy), 16'd0);
    chk("ri_f_ack", 16'(f_ack), 16'd0);
    tick();
    tick();
    rst = 1'b0;
    na = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (f_ack || d_ack) na++;
    end
    chk("ri_no_ack", 16'(na), 16'd0);
    run_txn("f1", 1'b0, 1'b1, 16'h0001, 16'h0000, lat, en_cyc, rdata, err, rw_seen);
    chk("f1_lat", 16'(lat), 16'd8);
    chk("f1_data", rdata, 16'h0081);
    chk("f1_err", 16'(err), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
